control_unit_pipe: RTL and testbench

- Parametrised, registered successor of the combinational MIPS controller. Decodes op_code/funct in ID.
- Resolves beq/bne/j, registers the control bundle into an ID/EX control register, and tracks the multi-cycle multiplier in a small FSM.
- Generates its own stall and flush so the hazard logic for the multiplier sits in one block.

---
 rtl/cu_pkg.sv | 84 ++++++++
 rtl/cu_mult_tracker.sv | 71 +++++++
 rtl/control_unit_pipe.sv | 248 ++++++++++++++++++++++++
 tb/tb_control_unit_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the pipelined MIPS control unit:
//   - opcode / funct field encodings of the supported instructions
//   - ALU function and result-mux (out_select) encodings
//   - multiplier tracker state type
//   - the registered control bundle and the decode result structs
// No ports (package).
// -----------------------------------------------------------------------------
package cu_pkg;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field values for R-type
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Native widths of the encodings below
    localparam int ALU_CODE_W = 4;
    localparam int OSEL_CODE_W = 2;

    // ALU function codes; 0 is reserved so an all-zero bundle means "no ALU op"
    localparam logic [ALU_CODE_W-1:0] ALU_NOP = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'd5;

    // Result mux select codes
    localparam logic [OSEL_CODE_W-1:0] OSEL_ALU = 2'd0;
    localparam logic [OSEL_CODE_W-1:0] OSEL_HI  = 2'd1;
    localparam logic [OSEL_CODE_W-1:0] OSEL_LO  = 2'd2;

    // Multiplier tracker states
    typedef enum logic {
        MT_IDLE = 1'b0,
        MT_BUSY = 1'b1
    } mt_state_e;

    // Control bundle carried in the ID/EX register
    typedef struct packed {
        logic                   reg_write;
        logic                   reg_dst;
        logic                   alu_src_a;
        logic                   mem_write;
        logic                   mem_read;
        logic                   mem_to_reg;
        logic                   se_ze;
        logic                   start_mult;
        logic                   mult_sign;
        logic [ALU_CODE_W-1:0]  alu_func;
        logic [OSEL_CODE_W-1:0] out_select;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Full decode result: the bundle plus flags consumed only inside ID
    typedef struct packed {
        ctrl_t ctrl;
        logic  is_beq;
        logic  is_bne;
        logic  is_j;
        logic  uses_hilo;  // mult, multu, mfhi, mflo: must wait for the multiplier
    } dec_t;

endpackage

// File: rtl/cu_mult_tracker.sv
// -----------------------------------------------------------------------------
// cu_mult_tracker
// Tracks the multi-cycle multiplier: IDLE -> BUSY on start, counts down
// MULT_LATENCY cycles, then back to IDLE.
// Parameters: MULT_LATENCY (2..15) cycles from start until HI/LO are valid.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (forces IDLE, counter 0)
//   start in  a mult/multu issues this cycle
//   busy  out tracker is in BUSY
// -----------------------------------------------------------------------------
module cu_mult_tracker
    import cu_pkg::*;
#(
    parameter int MULT_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);

    mt_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MT_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MT_IDLE: begin
                if (start) begin
                    state_d = MT_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            MT_BUSY: begin
                // Leave BUSY on the cycle the count is exhausted, so a waiting
                // mfhi/mflo is still held during that last cycle.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = MT_IDLE;
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = MT_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign busy = (state_q == MT_BUSY);

endmodule

// File: rtl/control_unit_pipe.sv
// -----------------------------------------------------------------------------
// control_unit_pipe
// Registered MIPS controller: decodes op_code/funct in ID, resolves beq/bne/j,
// generates multiplier stall and IF flush, and registers the control bundle
// into the ID/EX stage.
// Optional feature macro: CU_ILLEGAL_TRAP_EN adds the sticky illegal_op flag
// and the captured illegal_code; without it illegal encodings issue as valid
// all-zero bundles.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   op_code, funct         ID instruction fields
//   eq_ne                  ID register comparator (1 = equal)
//   id_valid               ID holds a real instruction
//   ex_ready               EX can accept; 0 holds ID/EX
//   flush                  external squash of the ID instruction
//   stall                  hold PC and IF/ID
//   if_flush               squash IF/ID (taken branch or jump)
//   pc_source              {jump, branch_taken}
//   ex_valid, ex_*         registered ID/EX control bundle
//   mult_busy              multiplier tracker is BUSY
//   illegal_op/illegal_code (CU_ILLEGAL_TRAP_EN only)
// -----------------------------------------------------------------------------
module control_unit_pipe
    import cu_pkg::*;
#(
    parameter int MULT_LATENCY = 4,
    parameter int ALU_FUNC_W   = 4,
    parameter int OUT_SEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            op_code,
    input  logic [5:0]            funct,
    input  logic                  eq_ne,
    input  logic                  id_valid,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  stall,
    output logic                  if_flush,
    output logic [1:0]            pc_source,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_reg_dst,
    output logic                  ex_ALUSrc_A,
    output logic                  ex_mem_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic                  ex_se_ze,
    output logic                  ex_start_mult,
    output logic                  ex_mult_sign,
    output logic [ALU_FUNC_W-1:0] ex_ALU_Func,
    output logic [OUT_SEL_W-1:0]  ex_out_select,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic                  illegal_op,
    output logic [11:0]           illegal_code,
`endif
    output logic                  mult_busy
);

    // Decode one instruction into its control bundle and ID-stage flags.
    // Unknown encodings return an all-zero result.
    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        d.ctrl.reg_write = 1'b1;
                        d.ctrl.reg_dst   = 1'b1;
                        case (fn)
                            FN_ADD:  d.ctrl.alu_func = ALU_ADD;
                            FN_SUB:  d.ctrl.alu_func = ALU_SUB;
                            FN_AND:  d.ctrl.alu_func = ALU_AND;
                            FN_OR:   d.ctrl.alu_func = ALU_OR;
                            default: d.ctrl.alu_func = ALU_SLT;
                        endcase
                    end
                    FN_MULT, FN_MULTU: begin
                        d.ctrl.start_mult = 1'b1;
                        d.ctrl.mult_sign  = (fn == FN_MULT);
                        d.uses_hilo       = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        d.ctrl.reg_write  = 1'b1;
                        d.ctrl.reg_dst    = 1'b1;
                        d.ctrl.out_select = (fn == FN_MFHI) ? OSEL_HI : OSEL_LO;
                        d.uses_hilo       = 1'b1;
                    end
                    default: d = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_src_a = 1'b1;
                d.ctrl.se_ze     = 1'b1;
                d.ctrl.alu_func  = ALU_ADD;
            end
            OP_ANDI, OP_ORI: begin
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_src_a = 1'b1;
                d.ctrl.alu_func  = (op == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_LW: begin
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.alu_src_a  = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.se_ze      = 1'b1;
                d.ctrl.alu_func   = ALU_ADD;
            end
            OP_SW: begin
                d.ctrl.alu_src_a = 1'b1;
                d.ctrl.mem_write = 1'b1;
                d.ctrl.se_ze     = 1'b1;
                d.ctrl.alu_func  = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                // Branches compare in ID; the bundle never writes state.
                d.ctrl.se_ze    = 1'b1;
                d.ctrl.alu_func = ALU_SUB;
                d.is_beq        = (op == OP_BEQ);
                d.is_bne        = (op == OP_BNE);
            end
            OP_J: begin
                d.is_j = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    dec_t  dec_s;
    logic  mult_busy_s;
    logic  mult_hazard_s;
    logic  stall_s;
    logic  issue_s;
    logic  branch_taken_s;
    logic  jump_s;
    logic  mult_start_s;
    ctrl_t ex_q, ex_d;
    logic  ex_valid_q, ex_valid_d;

    // ID-stage decode, hazard and branch resolution
    always_comb begin
        dec_s          = decode(op_code, funct);
        mult_hazard_s  = id_valid & mult_busy_s & dec_s.uses_hilo;
        stall_s        = mult_hazard_s | (id_valid & ~ex_ready);
        issue_s        = id_valid & ~stall_s & ~flush;
        branch_taken_s = issue_s & ((dec_s.is_beq & eq_ne) | (dec_s.is_bne & ~eq_ne));
        jump_s         = issue_s & dec_s.is_j;
        mult_start_s   = issue_s & dec_s.ctrl.start_mult;
    end

    // ID/EX next value: hold on back-pressure, load on issue, else bubble
    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (ex_ready) begin
            if (issue_s) begin
                ex_d       = dec_s.ctrl;
                ex_valid_d = 1'b1;
            end else begin
                ex_d       = '0;
                ex_valid_d = 1'b0;
            end
        end else begin
            ex_d       = ex_q;
            ex_valid_d = ex_valid_q;
        end
    end

    // ID/EX control register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    cu_mult_tracker #(
        .MULT_LATENCY (MULT_LATENCY)
    ) u_mult_tracker (
        .clk   (clk),
        .rst   (rst),
        .start (mult_start_s),
        .busy  (mult_busy_s)
    );

`ifdef CU_ILLEGAL_TRAP_EN
    // An encoding is legal when it decodes to something other than all-zero
    // controls; j is the only legal instruction with an all-zero bundle.
    function automatic logic is_legal(input dec_t d);
        return (d.ctrl != '0) | d.is_j;
    endfunction

    logic        illegal_q, illegal_d;
    logic [11:0] illegal_code_q, illegal_code_d;

    // Sticky trap: capture the first illegal encoding that would issue
    always_comb begin
        illegal_d      = illegal_q;
        illegal_code_d = illegal_code_q;
        if (issue_s && !is_legal(dec_s) && !illegal_q) begin
            illegal_d      = 1'b1;
            illegal_code_d = {op_code, funct};
        end else begin
            illegal_d      = illegal_q;
            illegal_code_d = illegal_code_q;
        end
    end

    // Trap registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q      <= 1'b0;
            illegal_code_q <= 12'h000;
        end else begin
            illegal_q      <= illegal_d;
            illegal_code_q <= illegal_code_d;
        end
    end

    assign illegal_op   = illegal_q;
    assign illegal_code = illegal_code_q;
`endif

    assign stall         = stall_s;
    assign pc_source     = {jump_s, branch_taken_s};
    assign if_flush      = jump_s | branch_taken_s;
    assign mult_busy     = mult_busy_s;
    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_reg_dst    = ex_q.reg_dst;
    assign ex_ALUSrc_A   = ex_q.alu_src_a;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_se_ze      = ex_q.se_ze;
    assign ex_start_mult = ex_q.start_mult;
    assign ex_mult_sign  = ex_q.mult_sign;
    assign ex_ALU_Func   = ALU_FUNC_W'(ex_q.alu_func);
    assign ex_out_select = OUT_SEL_W'(ex_q.out_select);

endmodule

// File: tb/tb_control_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_control_unit_pipe
// Self-checking bench for control_unit_pipe: directed scenarios plus a
// randomized run, all compared against a cycle-level reference model that
// tracks the expected ID/EX bundle, its valid bit and the remaining
// multiplier busy cycles as a plain integer.
// -----------------------------------------------------------------------------
module tb_control_unit_pipe;
    import cu_pkg::ALU_ADD;
    import cu_pkg::ALU_SUB;
    import cu_pkg::ALU_AND;
    import cu_pkg::ALU_OR;
    import cu_pkg::ALU_SLT;
    import cu_pkg::OSEL_ALU;
    import cu_pkg::OSEL_HI;
    import cu_pkg::OSEL_LO;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op_code, funct;
    logic       eq_ne, id_valid, ex_ready, flush;
    logic       stall, if_flush, ex_valid, mult_busy;
    logic [1:0] pc_source;
    logic       ex_reg_write, ex_reg_dst, ex_ALUSrc_A, ex_mem_write, ex_mem_read;
    logic       ex_mem_to_reg, ex_se_ze, ex_start_mult, ex_mult_sign;
    logic [3:0] ex_ALU_Func;
    logic [1:0] ex_out_select;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        illegal_op;
    logic [11:0] illegal_code;
`endif

    control_unit_pipe #(.MULT_LATENCY(LAT), .ALU_FUNC_W(4), .OUT_SEL_W(2)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .eq_ne(eq_ne),
        .id_valid(id_valid), .ex_ready(ex_ready), .flush(flush),
        .stall(stall), .if_flush(if_flush), .pc_source(pc_source), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_reg_dst(ex_reg_dst), .ex_ALUSrc_A(ex_ALUSrc_A),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_se_ze(ex_se_ze), .ex_start_mult(ex_start_mult), .ex_mult_sign(ex_mult_sign),
        .ex_ALU_Func(ex_ALU_Func), .ex_out_select(ex_out_select),
`ifdef CU_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op), .illegal_code(illegal_code),
`endif
        .mult_busy(mult_busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [14:0] m_ex;
    logic        m_valid;
    int          m_busy_left;

    // Values observed mid-cycle by the last step
    logic       obs_stall, obs_iff, obs_start;
    logic [1:0] obs_pcsrc;

    // Expected bundle {rw, rdst, srcA, mw, mr, m2r, se, start, sign, alu[3:0], osel[1:0]}
    function automatic logic [14:0] exp_ctrl(input logic [5:0] op, input logic [5:0] fn);
        logic rw, rdst, srca, mw, mr, m2r, se, st, sg;
        logic [3:0] alu;
        logic [1:0] os;
        {rw, rdst, srca, mw, mr, m2r, se, st, sg} = 9'b0;
        alu = 4'd0;
        os  = OSEL_ALU;
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) begin
                rw = 1'b1; rdst = 1'b1;
                alu = (fn == 6'h20) ? ALU_ADD : (fn == 6'h22) ? ALU_SUB :
                      (fn == 6'h24) ? ALU_AND : (fn == 6'h25) ? ALU_OR : ALU_SLT;
            end
            if (fn == 6'h18) begin st = 1'b1; sg = 1'b1; end
            if (fn == 6'h19) st = 1'b1;
            if (fn == 6'h10) begin rw = 1'b1; rdst = 1'b1; os = OSEL_HI; end
            if (fn == 6'h12) begin rw = 1'b1; rdst = 1'b1; os = OSEL_LO; end
        end
        if (op == 6'h08 || op == 6'h09) begin rw = 1'b1; srca = 1'b1; se = 1'b1; alu = ALU_ADD; end
        if (op == 6'h0C) begin rw = 1'b1; srca = 1'b1; alu = ALU_AND; end
        if (op == 6'h0D) begin rw = 1'b1; srca = 1'b1; alu = ALU_OR; end
        if (op == 6'h23) begin rw = 1'b1; srca = 1'b1; mr = 1'b1; m2r = 1'b1; se = 1'b1; alu = ALU_ADD; end
        if (op == 6'h2B) begin srca = 1'b1; mw = 1'b1; se = 1'b1; alu = ALU_ADD; end
        if (op == 6'h04 || op == 6'h05) begin se = 1'b1; alu = ALU_SUB; end
        return {rw, rdst, srca, mw, mr, m2r, se, st, sg, alu, os};
    endfunction

    function automatic logic [14:0] dut_bundle();
        return {ex_reg_write, ex_reg_dst, ex_ALUSrc_A, ex_mem_write, ex_mem_read,
                ex_mem_to_reg, ex_se_ze, ex_start_mult, ex_mult_sign, ex_ALU_Func, ex_out_select};
    endfunction

    task automatic apply_reset();
        rst = 1'b1; id_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        op_code = 6'h00; funct = 6'h00; eq_ne = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ex = 15'd0; m_valid = 1'b0; m_busy_left = 0;
    endtask

    // One clock cycle: drive, compare mid-cycle against the model, advance the model
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic eq, input logic idv, input logic rdy, input logic fl);
        logic hilo, hz, e_stall, e_issue, e_bt, e_j;
        op_code = op; funct = fn; eq_ne = eq; id_valid = idv; ex_ready = rdy; flush = fl;
        @(negedge clk);
        hilo    = (op == 6'h00) && (fn == 6'h18 || fn == 6'h19 || fn == 6'h10 || fn == 6'h12);
        hz      = idv && hilo && (m_busy_left > 0);
        e_stall = hz || (idv && !rdy);
        e_issue = idv && !e_stall && !fl;
        e_bt    = e_issue && ((op == 6'h04 && eq) || (op == 6'h05 && !eq));
        e_j     = e_issue && (op == 6'h02);
        obs_stall = stall; obs_pcsrc = pc_source; obs_iff = if_flush; obs_start = ex_start_mult;
        n_total++; if (stall !== e_stall) $display("FAIL %s stall: got %b want %b", tag, stall, e_stall); else n_pass++;
        n_total++; if (pc_source !== {e_j, e_bt}) $display("FAIL %s pc_source: got %b want %b", tag, pc_source, {e_j, e_bt}); else n_pass++;
        n_total++; if (if_flush !== (e_j | e_bt)) $display("FAIL %s if_flush: got %b want %b", tag, if_flush, e_j | e_bt); else n_pass++;
        n_total++; if (mult_busy !== (m_busy_left > 0)) $display("FAIL %s mult_busy: got %b want %b", tag, mult_busy, m_busy_left > 0); else n_pass++;
        n_total++; if (ex_valid !== m_valid) $display("FAIL %s ex_valid: got %b want %b", tag, ex_valid, m_valid); else n_pass++;
        n_total++; if (dut_bundle() !== m_ex) $display("FAIL %s ex_bundle: got %h want %h", tag, dut_bundle(), m_ex); else n_pass++;
        @(posedge clk); #1;
        if (rdy) begin
            m_valid = e_issue;
            m_ex    = e_issue ? exp_ctrl(op, fn) : 15'd0;
        end
        if (m_busy_left > 0) m_busy_left--;
        else if (e_issue && op == 6'h00 && (fn == 6'h18 || fn == 6'h19)) m_busy_left = LAT;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL reset ex_valid: got %b want 0", ex_valid); else n_pass++;
        n_total++; if (dut_bundle() !== 15'd0) $display("FAIL reset bundle: got %h want 0", dut_bundle()); else n_pass++;
        n_total++; if (mult_busy !== 1'b0) $display("FAIL reset mult_busy: got %b want 0", mult_busy); else n_pass++;
        n_total++; if ({stall, pc_source, if_flush} !== 4'b0) $display("FAIL reset comb: got %b want 0000", {stall, pc_source, if_flush}); else n_pass++;
    endtask

    task automatic test_add();
        step("add", 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, 1'b0);
        n_total++;
        if ({ex_valid, ex_reg_write, ex_reg_dst} !== 3'b111 || ex_ALU_Func !== ALU_ADD)
            $display("FAIL add_bundle: got v%b rw%b rd%b alu%h want 111 alu%h", ex_valid, ex_reg_write, ex_reg_dst, ex_ALU_Func, ALU_ADD);
        else n_pass++;
    endtask

    task automatic test_branch();
        step("beq_taken", 6'h04, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        n_total++; if ({obs_pcsrc, obs_iff} !== 3'b011) $display("FAIL beq_taken: got %b want 011", {obs_pcsrc, obs_iff}); else n_pass++;
        n_total++; if (ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) $display("FAIL beq_nowrite: got %b%b want 00", ex_reg_write, ex_mem_write); else n_pass++;
        step("beq_nt", 6'h04, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        n_total++; if (obs_pcsrc !== 2'b00) $display("FAIL beq_not_taken: got %b want 00", obs_pcsrc); else n_pass++;
        step("bne_taken", 6'h05, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        step("jump", 6'h02, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        n_total++; if ({obs_pcsrc, obs_iff} !== 3'b101) $display("FAIL jump: got %b want 101", {obs_pcsrc, obs_iff}); else n_pass++;
    endtask

    task automatic test_mult_mflo();
        int stalls = 0;
        int starts = 0;
        bit done = 0;
        apply_reset();
        step("mult", 6'h00, 6'h18, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20 && !done; k++) begin
            step("mflo_wait", 6'h00, 6'h12, 1'b0, 1'b1, 1'b1, 1'b0);
            if (obs_start) starts++;
            if (obs_stall) stalls++; else done = 1;
        end
        n_total++; if (stalls != LAT) $display("FAIL mult_stall_cycles: got %0d want %0d", stalls, LAT); else n_pass++;
        n_total++; if (ex_out_select !== OSEL_LO || ex_valid !== 1'b1) $display("FAIL mflo_issue: got osel %b v%b want %b v1", ex_out_select, ex_valid, OSEL_LO); else n_pass++;
        step("after_mflo", 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        if (obs_start) starts++;
        n_total++; if (starts != 1) $display("FAIL start_mult_pulses: got %0d want 1", starts); else n_pass++;
    endtask

    task automatic test_ex_ready();
        apply_reset();
        step("lw", 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step("hold", 6'h00, 6'h22, 1'b0, 1'b1, 1'b0, 1'b0);
            n_total++;
            if (obs_stall !== 1'b1 || ex_mem_read !== 1'b1 || ex_valid !== 1'b1)
                $display("FAIL hold_lw: got stall%b mr%b v%b want 111", obs_stall, ex_mem_read, ex_valid);
            else n_pass++;
        end
        step("release", 6'h00, 6'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        n_total++; if (ex_mem_read !== 1'b0 || ex_ALU_Func !== ALU_SUB) $display("FAIL release_sub: got mr%b alu%h want mr0 alu%h", ex_mem_read, ex_ALU_Func, ALU_SUB); else n_pass++;
    endtask

    task automatic test_flush_multu();
        apply_reset();
        step("add_pre", 6'h00, 6'h25, 1'b0, 1'b1, 1'b1, 1'b0);
        step("flush_multu", 6'h00, 6'h19, 1'b0, 1'b1, 1'b1, 1'b1);
        n_total++; if (mult_busy !== 1'b0 || ex_valid !== 1'b0) $display("FAIL flush_multu: got busy%b v%b want 00", mult_busy, ex_valid); else n_pass++;
    endtask

    task automatic test_rst_busy();
        apply_reset();
        step("mult_b", 6'h00, 6'h19, 1'b0, 1'b1, 1'b1, 1'b0);
        step("idle_b", 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1; op_code = 6'h00; funct = 6'h10; id_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ex = 15'd0; m_valid = 1'b0; m_busy_left = 0;
        n_total++;
        if (mult_busy !== 1'b0 || stall !== 1'b0 || ex_valid !== 1'b0 || dut_bundle() !== 15'd0)
            $display("FAIL rst_busy: got busy%b stall%b v%b bundle%h want all 0", mult_busy, stall, ex_valid, dut_bundle());
        else n_pass++;
        step("mfhi_after_rst", 6'h00, 6'h10, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [11:0] codes [20];
        codes = '{12'h020, 12'h022, 12'h024, 12'h025, 12'h02A, 12'h018, 12'h019, 12'h010,
                  12'h012, 12'h200, 12'h240, 12'h300, 12'h340, 12'h8C0, 12'hAC0, 12'h100,
                  12'h140, 12'h080, 12'hFC0, 12'h03F};
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            logic [11:0] c;
            c = codes[$urandom_range(0, 19)];
            if (c[11:6] != 6'h00) c[5:0] = 6'($urandom);
            step("random", c[11:6], c[5:0], 1'($urandom), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0));
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step("b2b_add", 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, 1'b0);
        step("b2b_sw",  6'h2B, 6'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        step("b2b_ori", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        step("b2b_ill", 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        n_total++; if (ex_valid !== 1'b1 || dut_bundle() !== 15'd0) $display("FAIL illegal_bubble: got v%b bundle%h want v1 0", ex_valid, dut_bundle()); else n_pass++;
        step("b2b_end", 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_mult_mflo();
        test_ex_ready();
        test_flush_multu();
        test_rst_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
